// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among four byte streams.
// Define UART_ARB_CHECKSUM_EN to append an XOR checksum byte after every packet.
module uart_tx_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NREQ-1:0]     ReqValid,
    input  logic [8*NREQ-1:0]   ReqData,
    input  logic [NREQ-1:0]     ReqLast,
    output logic [NREQ-1:0]     ReqReady,
    output logic [7:0]          TxData,
    output logic                TxEn,
    input  logic                TxDone,
    output logic                Busy,
    output logic [1:0]          GrantId
);

`ifdef UART_ARB_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT, ST_GAP, ST_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT, ST_GAP
    } state_t;
`endif

    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  ptr_q;
    logic        busy_q;
    logic [7:0]  txdata_q;
    logic        txen_q;
    logic        last_q;
    logic [7:0]  gap_cnt_q;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0]  csum_q;
    logic        csum_sent_q;
`endif

    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;
    logic [7:0]  sel_byte;
    logic        owner_valid;
    state_t      post_state;
    logic        post_release;

    assign sel_byte    = ReqData[{grant_q, 3'b000} +: 8];
    assign owner_valid = ReqValid[grant_q];

    // First valid requester at or after the rotating pointer.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && ReqValid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        post_state   = ST_SEND;
        post_release = 1'b0;
        if (last_q) begin
`ifdef UART_ARB_CHECKSUM_EN
            if (!csum_sent_q) begin
                post_state = ST_CSUM;
            end else begin
                post_state   = ST_IDLE;
                post_release = 1'b1;
            end
`else
            post_state   = ST_IDLE;
            post_release = 1'b1;
`endif
        end
    end

    always_comb begin
        ReqReady = '0;
        if (state_q == ST_SEND && owner_valid) begin
            ReqReady[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            txdata_q    <= '0;
            txen_q      <= 1'b0;
            last_q      <= 1'b0;
            gap_cnt_q   <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            csum_q      <= '0;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            txen_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        grant_q     <= pick;
                        busy_q      <= 1'b1;
`ifdef UART_ARB_CHECKSUM_EN
                        csum_q      <= '0;
                        csum_sent_q <= 1'b0;
`endif
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (owner_valid) begin
                        txdata_q <= sel_byte;
                        last_q   <= ReqLast[grant_q];
`ifdef UART_ARB_CHECKSUM_EN
                        csum_q   <= csum_q ^ sel_byte;
`endif
                        txen_q   <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A done coincident with our own start pulse belongs to no byte of ours.
                    if (TxDone && !txen_q) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= ST_GAP;
                        end else begin
                            state_q <= post_state;
                            if (post_release) begin
                                busy_q <= 1'b0;
                                ptr_q  <= grant_q + 2'd1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q <= post_state;
                        if (post_release) begin
                            busy_q <= 1'b0;
                            ptr_q  <= grant_q + 2'd1;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
`ifdef UART_ARB_CHECKSUM_EN
                ST_CSUM: begin
                    txdata_q    <= csum_q;
                    txen_q      <= 1'b1;
                    csum_sent_q <= 1'b1;
                    state_q     <= ST_WAIT;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TxData  = txdata_q;
    assign TxEn    = txen_q;
    assign Busy    = busy_q;
    assign GrantId = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (GAP_CYCLES=0 and GAP_CYCLES=3 instances).
module tb_uart_tx_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [3:0]  ReqValid = '0;
    logic [31:0] ReqData  = '0;
    logic [3:0]  ReqLast  = '0;
    logic [3:0]  ReqReady;
    logic [7:0]  TxData;
    logic        TxEn;
    logic        TxDone = 1'b0;
    logic        Busy;
    logic [1:0]  GrantId;

    logic [3:0]  g_valid = '0;
    logic [31:0] g_data  = '0;
    logic [3:0]  g_last  = '0;
    logic [3:0]  g_ready;
    logic [7:0]  g_txdata;
    logic        g_txen;
    logic        g_done = 1'b0;
    logic        g_busy;
    logic [1:0]  g_grant;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 Clk = ~Clk;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0)) u_dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqData(ReqData), .ReqLast(ReqLast),
        .ReqReady(ReqReady), .TxData(TxData), .TxEn(TxEn), .TxDone(TxDone),
        .Busy(Busy), .GrantId(GrantId)
    );

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(3)) u_gap (
        .Clk(Clk), .Rst(Rst), .ReqValid(g_valid), .ReqData(g_data), .ReqLast(g_last),
        .ReqReady(g_ready), .TxData(g_txdata), .TxEn(g_txen), .TxDone(g_done),
        .Busy(g_busy), .GrantId(g_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge where TxEn is high (bounded).
    task automatic wait_txen(input string tag, output logic [7:0] d, output logic [1:0] gid);
        int unsigned n = 0;
        @(negedge Clk);
        while (TxEn !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check({tag, " txen"}, 32'(TxEn), 32'd1);
        d   = TxData;
        gid = GrantId;
    endtask

    // One byte through the transmitter; returns one cycle after TxDone was sampled.
    task automatic serve(input string tag, output logic [7:0] d, output logic [1:0] gid);
        wait_txen(tag, d, gid);
        repeat (3) @(negedge Clk);
        TxDone = 1'b1;
        @(negedge Clk);
        TxDone = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " Busy"},     32'(Busy),     32'd0);
        check({tag, " TxEn"},     32'(TxEn),     32'd0);
        check({tag, " TxData"},   32'(TxData),   32'h00);
        check({tag, " GrantId"},  32'(GrantId),  32'd0);
        check({tag, " ReqReady"}, 32'(ReqReady), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] gid;
        logic       acc_txen, acc_busy_low;
        logic [3:0] acc_ready;

        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");

        // Single byte from requester 2
        Rst      = 1'b0;
        ReqValid = 4'b0100;
        ReqData  = 32'h00A5_0000;
        ReqLast  = 4'b0100;
        @(negedge Clk);
        check("single GrantId",  32'(GrantId),  32'd2);
        check("single Busy",     32'(Busy),     32'd1);
        check("single ReqReady", 32'(ReqReady), 32'b0100);
        @(negedge Clk);
        check("single TxEn",     32'(TxEn),     32'd1);
        check("single TxData",   32'(TxData),   32'hA5);
        ReqValid = '0;
        @(negedge Clk);
        check("single TxEn width", 32'(TxEn), 32'd0);
        repeat (18) @(negedge Clk);
        TxDone = 1'b1;
        @(negedge Clk);
        TxDone = 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
        check("single Busy held for csum", 32'(Busy), 32'd1);
        serve("single csum", d, gid);
        check("single csum byte", 32'(d), 32'hA5);
        check("single Busy after csum", 32'(Busy), 32'd0);
`else
        check("single Busy release", 32'(Busy), 32'd0);
`endif

        // Fairness from a fresh pointer
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst      = 1'b0;
        ReqValid = 4'hF;
        ReqLast  = 4'hF;
        ReqData  = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            serve("fair", d, gid);
            check($sformatf("fair grant %0d", k), 32'(gid), 32'(k % 4));
            check($sformatf("fair data %0d", k),  32'(d),   32'h10 + 32'(k % 4));
`ifdef UART_ARB_CHECKSUM_EN
            serve("fair csum", d, gid);
            check($sformatf("fair csum %0d", k), 32'(d), 32'h10 + 32'(k % 4));
`endif
        end
        ReqValid = '0;

        // Packet lock: requester 1 holds the grant across three bytes
        ReqValid = 4'b0011;
        ReqData  = 32'h0000_0055;
        for (int j = 0; j < 3; j++) begin
            ReqData[15:8] = 8'(j + 1);
            ReqLast       = (j == 2) ? 4'b0011 : 4'b0001;
            serve("lock", d, gid);
            check($sformatf("lock grant %0d", j), 32'(gid), 32'd1);
            check($sformatf("lock data %0d", j),  32'(d),   32'(j + 1));
        end
        ReqValid = 4'b0001;
`ifdef UART_ARB_CHECKSUM_EN
        serve("lock csum", d, gid);
        check("lock csum byte", 32'(d), 32'h00);
`endif
        serve("lock next", d, gid);
        check("lock next grant", 32'(gid), 32'd0);
        check("lock next data",  32'(d),   32'h55);
        ReqValid = '0;
`ifdef UART_ARB_CHECKSUM_EN
        serve("lock next csum", d, gid);
        check("lock next csum byte", 32'(d), 32'h55);
`endif

        // Stall: owner 1 goes quiet mid-packet while requester 2 waits
        ReqValid = 4'b0110;
        ReqData  = 32'h0099_7700;
        ReqLast  = 4'b0100;
        serve("stall first", d, gid);
        check("stall first grant", 32'(gid), 32'd1);
        check("stall first data",  32'(d),   32'h77);
        ReqValid     = 4'b0100;
        acc_txen     = 1'b0;
        acc_busy_low = 1'b0;
        acc_ready    = '0;
        for (int i = 0; i < 50; i++) begin
            TxDone = (i == 25);
            @(negedge Clk);
            acc_txen     = acc_txen | TxEn;
            acc_busy_low = acc_busy_low | ~Busy;
            acc_ready    = acc_ready | ReqReady;
        end
        TxDone = 1'b0;
        check("stall no TxEn",     32'(acc_txen),     32'd0);
        check("stall Busy held",   32'(acc_busy_low), 32'd0);
        check("stall no ReqReady", 32'(acc_ready),    32'd0);
        check("stall grant kept",  32'(GrantId),      32'd1);
        ReqValid      = 4'b0110;
        ReqData[15:8] = 8'h78;
        ReqLast       = 4'b0110;
        serve("stall resume", d, gid);
        check("stall resume grant", 32'(gid), 32'd1);
        check("stall resume data",  32'(d),   32'h78);
`ifdef UART_ARB_CHECKSUM_EN
        serve("stall csum", d, gid);
        check("stall csum byte", 32'(d), 32'h0F);
`endif
        ReqValid = 4'b0100;
        serve("stall other", d, gid);
        check("stall other grant", 32'(gid), 32'd2);
        check("stall other data",  32'(d),   32'h99);
        ReqValid = '0;
`ifdef UART_ARB_CHECKSUM_EN
        serve("stall other csum", d, gid);
        check("stall other csum byte", 32'(d), 32'h99);
`endif

        // Spurious TxDone while idle
        @(negedge Clk);
        TxDone = 1'b1;
        @(negedge Clk);
        TxDone = 1'b0;
        check("idle spurious Busy", 32'(Busy), 32'd0);
        check("idle spurious TxEn", 32'(TxEn), 32'd0);
        @(negedge Clk);
        check("idle spurious TxEn later", 32'(TxEn), 32'd0);

        // Reset while waiting on a byte mid-packet
        ReqValid = 4'b1000;
        ReqData  = 32'h3C00_0000;
        ReqLast  = 4'b0000;
        wait_txen("rst", d, gid);
        check("rst pre grant", 32'(gid), 32'd3);
        Rst = 1'b1;
        @(negedge Clk);
        check_reset_outputs("rst in WAIT");
        Rst      = 1'b0;
        ReqValid = 4'b1010;
        @(negedge Clk);
        check("rst search from 0 Busy",    32'(Busy),    32'd1);
        check("rst search from 0 GrantId", 32'(GrantId), 32'd1);
        ReqValid = '0;
        Rst      = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        // GAP_CYCLES=3 instance: two-byte packet from requester 0
        g_valid = 4'b0001;
        g_data  = 32'h0000_00C1;
        g_last  = 4'b0000;
        begin
            int unsigned n = 0;
            @(negedge Clk);
            while (g_txen !== 1'b1 && n < 200) begin
                @(negedge Clk);
                n++;
            end
        end
        check("gap first TxEn", 32'(g_txen),   32'd1);
        check("gap first data", 32'(g_txdata), 32'hC1);
        @(negedge Clk);
        g_data = 32'h0000_00C2;
        g_last = 4'b0001;
        @(negedge Clk);
        g_done   = 1'b1;
        acc_txen = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            g_done = 1'b0;
            if (k < 5) acc_txen = acc_txen | g_txen;
            if (k == 4) check("gap ReqReady at t+4", 32'(g_ready), 32'b0001);
            if (k == 5) begin
                check("gap TxEn at t+5",  32'(g_txen),   32'd1);
                check("gap second data", 32'(g_txdata), 32'hC2);
            end
        end
        check("gap no early TxEn", 32'(acc_txen), 32'd0);
        g_valid = '0;
        repeat (2) @(negedge Clk);
        g_done = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            g_done = 1'b0;
`ifndef UART_ARB_CHECKSUM_EN
            if (k == 3) check("gap Busy during gap", 32'(g_busy), 32'd1);
            if (k == 4) check("gap Busy release",    32'(g_busy), 32'd0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
